// File: rtl/fsm_job_dispatcher.sv
// Job dispatcher: queues operands in a small FIFO and launches them one at a time into the FSM.
// Optional watchdog in WAIT enabled by defining DISPATCH_TIMEOUT_EN.
module fsm_job_dispatcher #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
`ifdef DISPATCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             start,
  output logic [WIDTH-1:0] d,
  input  logic             done,
  output logic             busy,
  output logic [7:0]       jobs_done
`ifdef DISPATCH_TIMEOUT_EN
  , output logic           timeout_err
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

`ifdef DISPATCH_TIMEOUT_EN
  localparam int unsigned TimW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TimW-1:0] TimerLast = TimW'(TIMEOUT_CYCLES - 1);
  logic [TimW-1:0] timer_q;
`endif

  typedef enum logic [1:0] {StIdle, StLaunch, StSettle, StWait} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push;
  logic             pop;

  // Full flag comes from registered count only; a same-cycle pop does not free a slot.
  assign in_ready = (count_q != FullCount);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == StIdle) && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      start       <= 1'b0;
      d           <= '0;
      busy        <= 1'b0;
      jobs_done   <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      timer_q     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            d       <= mem_q[rd_ptr_q];
            start   <= 1'b1;
            busy    <= 1'b1;
            state_q <= StLaunch;
          end
        end
        StLaunch: begin
          start   <= 1'b0;
          state_q <= StSettle;
`ifdef DISPATCH_TIMEOUT_EN
          timer_q <= '0;
`endif
        end
        // done may still be high from the previous job here, so it is not looked at.
        StSettle: state_q <= StWait;
        StWait: begin
          if (done) begin
            jobs_done <= jobs_done + 8'd1;
            busy      <= 1'b0;
            state_q   <= StIdle;
`ifdef DISPATCH_TIMEOUT_EN
          end else if (timer_q == TimerLast) begin
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            timer_q <= timer_q + TimW'(1);
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_job_dispatcher.sv
// Scoreboard bench for fsm_job_dispatcher: operands queued on push, checked at each start pulse.
// Define DISPATCH_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_fsm_job_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        start;
  logic [15:0] d;
  logic        done;
  logic        busy;
  logic [7:0]  jobs_done;
`ifdef DISPATCH_TIMEOUT_EN
  logic        timeout_err;
`endif

  int          errors = 0;
  int          checks = 0;
  int          start_cnt = 0;
  logic        prev_start = 1'b0;
  logic [15:0] cur_d = '0;
  logic [15:0] exp_q [$];

  fsm_job_dispatcher #(
    .WIDTH(16),
    .DEPTH(4)
`ifdef DISPATCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .start(start),
    .d(d),
    .done(done),
    .busy(busy),
    .jobs_done(jobs_done)
`ifdef DISPATCH_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every start pulse must match the oldest accepted operand.
  always @(negedge clk) begin
    if (start) begin
      start_cnt++;
      chk("start_one_cycle", prev_start, 0);
      chk("busy_at_start", busy, 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: d=%0h with nothing queued", d);
      end else begin
        chk("d_at_start", d, exp_q.pop_front());
      end
      cur_d = d;
    end else if (busy) begin
      chk("d_held", d, cur_d);
    end
    prev_start = start;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!start && n < 40);
    chk("start_seen", start, 1);
  endtask

  task automatic finish_job();
    tick(3);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; done = 1'b0;
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single job: start one cycle after the push edge, retire on done.
    in_valid = 1'b1; in_data = 16'h7F80; chk("t1_ready", in_ready, 1); exp_q.push_back(16'h7F80);
    @(negedge clk); in_valid = 1'b0;
    chk("t1_no_start_yet", start, 0);
    @(negedge clk); chk("t1_start", start, 1); chk("t1_busy", busy, 1);
    @(negedge clk); chk("t1_start_low", start, 0);
    tick(3); chk("t1_busy_wait", busy, 1);
    done = 1'b1;
    @(negedge clk); done = 1'b0;
    chk("t1_busy_done", busy, 0);
    chk("t1_jobs", jobs_done, 1);

    // Stale done held through LAUNCH and SETTLE: retire only in WAIT.
    done = 1'b1; in_valid = 1'b1; in_data = 16'h1234; exp_q.push_back(16'h1234);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); chk("t2_start", start, 1);
    @(negedge clk); chk("t2_busy_settle", busy, 1); chk("t2_jobs_settle", jobs_done, 1);
    @(negedge clk); chk("t2_busy_wait", busy, 1); chk("t2_jobs_wait", jobs_done, 1);
    @(negedge clk); chk("t2_busy_retired", busy, 0); chk("t2_jobs", jobs_done, 2);
    @(negedge clk); chk("t2_jobs_once", jobs_done, 2);
    done = 1'b0;

    // Fill FIFO while a job stalls, then push and pop at full.
    in_valid = 1'b1; in_data = 16'hAAAA; exp_q.push_back(16'hAAAA);
    @(negedge clk); in_valid = 1'b0;
    wait_start();
    for (int v = 1; v <= 4; v++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'(v);
      chk("t3_ready_fill", in_ready, 1);
      exp_q.push_back(16'(v));
    end
    @(negedge clk); in_data = 16'd5; chk("t3_full", in_ready, 0);
    tick(2); chk("t3_full_held", in_ready, 0);
    done = 1'b1;
    @(negedge clk); done = 1'b0;
    chk("t3_full_after_retire", in_ready, 0);
    @(negedge clk);
    chk("t3_ready_after_pop", in_ready, 1);
    chk("t3_start_1", start, 1);
    exp_q.push_back(16'd5);
    @(negedge clk); in_valid = 1'b0;
    chk("t3_full_again", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      finish_job();
      if (i < 4) wait_start();
    end
    chk("t3_jobs", jobs_done, 8);
    chk("t3_queue_drained", exp_q.size(), 0);

    // Reset while in WAIT with two entries queued.
    in_valid = 1'b1; in_data = 16'hAA01; exp_q.push_back(16'hAA01);
    @(negedge clk); in_data = 16'hB001; exp_q.push_back(16'hB001);
    @(negedge clk); in_data = 16'hB002; exp_q.push_back(16'hB002);
    @(negedge clk); in_valid = 1'b0;
    tick(4);
    chk("t5_busy_before", busy, 1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_start", start, 0);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_jobs", jobs_done, 0);
    reset = 1'b0;
    sc = start_cnt;
    tick(8);
    chk("t5_no_starts", start_cnt, sc);

`ifdef DISPATCH_TIMEOUT_EN
    // Watchdog: done never arrives, job abandoned after 8 WAIT cycles.
    in_valid = 1'b1; in_data = 16'hC001; exp_q.push_back(16'hC001);
    @(negedge clk); in_data = 16'hC002; exp_q.push_back(16'hC002);
    @(negedge clk); in_valid = 1'b0;
    chk("t6_start", start, 1);
    tick(9);
    chk("t6_no_err_yet", timeout_err, 0);
    chk("t6_busy_wait", busy, 1);
    tick(1);
    chk("t6_err", timeout_err, 1);
    chk("t6_idle", busy, 0);
    chk("t6_jobs_same", jobs_done, 0);
    @(negedge clk); chk("t6_next_start", start, 1);
    finish_job();
    chk("t6_jobs", jobs_done, 1);
    chk("t6_err_sticky", timeout_err, 1);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
